// File: rtl/wb_retire_monitor.sv
// Write-back retirement monitor: counts retirements and RUN cycles, detects the halt word,
// drains, and buffers retired words in a FWFT trace FIFO. Watchdog: WB_RETIRE_MONITOR_TIMEOUT_EN.
module wb_retire_monitor #(
  parameter logic [31:0] HALT_WORD      = 32'h0000_0001,
  parameter int unsigned DRAIN_CYCLES   = 10,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] wb_instr,
  input  logic        wb_valid,
  output logic [31:0] trace_data,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] retired_count,
  output logic [31:0] cycle_count,
  output logic        halted,
  output logic        done,
  output logic        overflow,
  output logic        timeout
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic        halted_q, halted_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] mem_q [FIFO_DEPTH];
`ifdef WB_RETIRE_MONITOR_TIMEOUT_EN
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
`endif

  logic fifo_empty, fifo_full, pop, accept, push;

  // Equal low bits with differing MSBs means the write pointer has lapped the read pointer.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && trace_ready;
  assign accept     = wb_valid && !start && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign push       = accept && (!fifo_full || pop);

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    state_d         = state_q;
    retired_count_d = retired_count_q;
    cycle_count_d   = cycle_count_q;
    drain_cnt_d     = drain_cnt_q;
    halted_d        = halted_q;
    done_d          = done_q;
    overflow_d      = overflow_q;
    wr_ptr_d        = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
`ifdef WB_RETIRE_MONITOR_TIMEOUT_EN
    wdog_d          = wdog_q;
    timeout_d       = timeout_q;
`endif

    if (start) begin
      state_d         = ST_RUN;
      retired_count_d = '0;
      cycle_count_d   = '0;
      drain_cnt_d     = '0;
      halted_d        = 1'b0;
      done_d          = 1'b0;
      overflow_d      = 1'b0;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
`ifdef WB_RETIRE_MONITOR_TIMEOUT_EN
      wdog_d          = '0;
      timeout_d       = 1'b0;
`endif
    end else begin
      if (accept) begin
        if (retired_count_q != '1) retired_count_d = retired_count_q + 32'd1;
        if (!push) overflow_d = 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
          if (wb_valid && wb_instr == HALT_WORD) begin
            halted_d    = 1'b1;
            drain_cnt_d = DRAIN_LOAD;
            state_d     = ST_DRAIN;
          end
`ifdef WB_RETIRE_MONITOR_TIMEOUT_EN
          if (wb_valid) begin
            wdog_d = '0;
          end else if (wdog_q == WDOG_LAST) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            wdog_d = wdog_q + 32'd1;
          end
`endif
        end
        ST_DRAIN: begin
          if (drain_cnt_q == 8'd0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q         <= ST_IDLE;
      retired_count_q <= '0;
      cycle_count_q   <= '0;
      drain_cnt_q     <= '0;
      halted_q        <= 1'b0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
`ifdef WB_RETIRE_MONITOR_TIMEOUT_EN
      wdog_q          <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      retired_count_q <= retired_count_d;
      cycle_count_q   <= cycle_count_d;
      drain_cnt_q     <= drain_cnt_d;
      halted_q        <= halted_d;
      done_q          <= done_d;
      overflow_q      <= overflow_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
`ifdef WB_RETIRE_MONITOR_TIMEOUT_EN
      wdog_q          <= wdog_d;
      timeout_q       <= timeout_d;
`endif
    end
  end

  // NOTE: storage is not reset; the pointers define validity and trace_data is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wb_instr;
  end

  assign trace_valid   = !fifo_empty;
  assign trace_data    = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign retired_count = retired_count_q;
  assign cycle_count   = cycle_count_q;
  assign halted        = halted_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
`ifdef WB_RETIRE_MONITOR_TIMEOUT_EN
  assign timeout       = timeout_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule
